// File: rtl/framebuffer_ctrl.sv
// rtl/framebuffer_ctrl.sv - double-buffered pixel store with clear engine and tear-free swap
module framebuffer_ctrl #(
    parameter int PIXELS = 192000,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              frame_start,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              swap_done,
    output logic              front_sel
);

    localparam int                MEM_AW   = $clog2(2 * PIXELS);
    localparam logic [ADDR_W:0]   PIX_LIM  = (ADDR_W + 1)'(PIXELS);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXELS - 1);
    localparam logic [MEM_AW-1:0] PIX_BASE = MEM_AW'(PIXELS);

    typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   mem [0:2*PIXELS-1];
    logic [ADDR_W-1:0]   count;
    logic [DATA_W-1:0]   color;

    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic                toggle;
    logic                load_clear;
    logic                rd_ok;
    logic [MEM_AW-1:0]   rphys;
    logic [MEM_AW-1:0]   wphys;

    assign wr_ready     = (state == IDLE) && !clear_req && !swap_req;
    assign clear_busy   = (state == CLEAR);
    assign swap_pending = (state == SWAP_WAIT);

    always_comb begin
        state_next = state;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;
        toggle     = 1'b0;
        load_clear = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    load_clear = 1'b1;
                    state_next = CLEAR;
                end else if (swap_req) begin
                    state_next = SWAP_WAIT;
                end else if (wr_valid && ({1'b0, wr_addr} < PIX_LIM)) begin
                    we    = 1'b1;
                    waddr = wr_addr;
                    wdata = wr_data;
                end
            end
            CLEAR: begin
                we    = 1'b1;
                waddr = count;
                wdata = color;
                if (count == LAST_PIX) begin
                    state_next = IDLE;
                end
            end
            SWAP_WAIT: begin
                if (frame_start) begin
                    toggle     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            front_sel <= 1'b0;
            swap_done <= 1'b0;
            count     <= '0;
            color     <= '0;
        end else begin
            state     <= state_next;
            swap_done <= toggle;
            if (toggle) begin
                front_sel <= ~front_sel;
            end
            if (load_clear) begin
                count <= '0;
                color <= clear_color;
            end else if (state == CLEAR) begin
                count <= count + 1'b1;
            end
        end
    end

    // Back buffer is always the one not on screen; out-of-range addresses never reach the RAM.
    assign wphys = (front_sel ? '0 : PIX_BASE) + MEM_AW'(waddr);
    assign rphys = (front_sel ? PIX_BASE : '0) + MEM_AW'(rd_addr);
    assign rd_ok = ({1'b0, rd_addr} < PIX_LIM);

    always_ff @(posedge clock) begin
        if (we && !reset) begin
            mem[wphys] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_ok) begin
            rd_data <= mem[rphys];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// tb/tb_framebuffer_ctrl.sv - self-checking bench for framebuffer_ctrl with a behavioural buffer model
module tb_framebuffer_ctrl;

    localparam int P  = 16;
    localparam int AW = 5;
    localparam int DW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          frame_start = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          clear_req = 1'b0;
    logic [DW-1:0] clear_color = '0;
    logic          clear_busy;
    logic          swap_req = 1'b0;
    logic          swap_pending;
    logic          swap_done;
    logic          front_sel;

    int checks = 0;
    int failures = 0;

    framebuffer_ctrl #(.PIXELS(P), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clear_req(clear_req), .clear_color(clear_color), .clear_busy(clear_busy),
        .swap_req(swap_req), .swap_pending(swap_pending), .swap_done(swap_done),
        .front_sel(front_sel)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: two pixel arrays, which one is shown, a remaining-clear count and a waiting flag.
    logic [DW-1:0] fb [2][P];
    bit            kn [2][P];
    int            m_front = 0;
    int            m_back;
    int            m_clear_left = 0;
    bit            m_waiting = 0;
    logic [DW-1:0] m_color = '0;
    logic [DW-1:0] m_rd = '0;
    bit            m_rd_kn = 1;
    bit            m_sd = 0;
    bit            chk_en = 0;

    task automatic model_step();
        m_back = 1 - m_front;
        if (rd_addr < P) begin
            m_rd    = fb[m_front][rd_addr];
            m_rd_kn = kn[m_front][rd_addr];
        end else begin
            m_rd    = '0;
            m_rd_kn = 1;
        end
        m_sd = 0;
        if (reset) begin
            m_clear_left = 0;
            m_waiting    = 0;
            m_front      = 0;
            m_rd         = '0;
            m_rd_kn      = 1;
        end else if (m_clear_left > 0) begin
            fb[m_back][P - m_clear_left] = m_color;
            kn[m_back][P - m_clear_left] = 1;
            m_clear_left--;
        end else if (m_waiting) begin
            if (frame_start) begin
                m_front   = 1 - m_front;
                m_waiting = 0;
                m_sd      = 1;
            end
        end else if (clear_req) begin
            m_color      = clear_color;
            m_clear_left = P;
        end else if (swap_req) begin
            m_waiting = 1;
        end else if (wr_valid && wr_addr < P) begin
            fb[m_back][wr_addr] = wr_data;
            kn[m_back][wr_addr] = 1;
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            chk("front_sel", front_sel, m_front);
            chk("clear_busy", clear_busy, 32'(m_clear_left > 0));
            chk("swap_pending", swap_pending, 32'(m_waiting));
            chk("swap_done", swap_done, 32'(m_sd));
            chk("wr_ready", wr_ready,
                32'(m_clear_left == 0 && !m_waiting && !clear_req && !swap_req));
            if (m_rd_kn) chk("rd_data", rd_data, m_rd);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        clear_req   = 1'b0;
        swap_req    = 1'b0;
        wr_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic do_clear(input logic [DW-1:0] c);
        clear_req   = 1'b1;
        clear_color = c;
        step();
        clear_req = 1'b0;
        repeat (P) step();
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        step();
        swap_req    = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    int pend, busy, bad;

    initial begin
        reset = 1'b1;
        step();
        chk_en = 1;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_front_sel", front_sel, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_swap_done", swap_done, 0);

        do_clear(4'h0);
        do_swap();
        do_clear(4'h0);
        do_swap();
        rd_addr = 3;
        step();
        #1 chk("t1_rd3", rd_data, 0);

        wr_valid = 1'b1; wr_addr = 5; wr_data = 4'hA;
        step();
        wr_valid = 1'b0;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        pend = 0;
        for (int k = 1; k <= 4; k++) begin
            frame_start = (k == 4);
            #1 pend += int'(swap_pending);
            step();
        end
        frame_start = 1'b0;
        #1;
        chk("t2_pending_cycles", pend, 4);
        chk("t2_swap_done", swap_done, 1);
        chk("t2_front_sel", front_sel, 1);
        rd_addr = 5;
        step();
        #1;
        chk("t2_rd5", rd_data, 4'hA);
        chk("t2_swap_done_once", swap_done, 0);

        clear_req = 1'b1; clear_color = 4'h7;
        step();
        clear_req = 1'b0;
        busy = 0; bad = 0;
        for (int k = 0; k < 20; k++) begin
            wr_valid = (k < P) ? 1'($urandom_range(0, 1)) : 1'b0;
            wr_addr  = AW'($urandom_range(0, P - 1));
            wr_data  = DW'($urandom);
            #1;
            busy += int'(clear_busy);
            if (clear_busy && wr_ready) bad++;
            step();
        end
        wr_valid = 1'b0;
        chk("t3_busy_cycles", busy, P);
        chk("t3_ready_while_busy", bad, 0);
        do_swap();
        for (int a = 0; a < P; a++) begin
            rd_addr = AW'(a);
            step();
            #1 chk("t3_rd_clear", rd_data, 4'h7);
        end

        clear_req = 1'b1; swap_req = 1'b1; wr_valid = 1'b1;
        wr_addr = 2; wr_data = 4'hF; clear_color = 4'h1;
        #1 chk("t4_wr_ready", wr_ready, 0);
        step();
        idle_in();
        repeat (P) step();
        #1;
        chk("t4_no_pending", swap_pending, 0);
        chk("t4_clear_done", clear_busy, 0);

        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        #1;
        chk("t5_idle_fs_front", front_sel, 0);
        chk("t5_idle_fs_done", swap_done, 0);
        clear_req = 1'b1; clear_color = 4'h9;
        step();
        clear_req = 1'b0;
        frame_start = 1'b1;
        repeat (P) step();
        frame_start = 1'b0;
        #1;
        chk("t5_clear_fs_front", front_sel, 0);
        chk("t5_clear_fs_done", swap_done, 0);
        wr_valid = 1'b1; wr_addr = 16; wr_data = 4'h4;
        #1 chk("t5_oob_ready", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        rd_addr = 0;
        step();
        #1 chk("t5_no_wrap", rd_data, 4'h7);
        rd_addr = 20;
        step();
        #1 chk("t5_rd_oob", rd_data, 0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        do_clear(4'h5);
        clear_req = 1'b1; clear_color = 4'h3;
        step();
        clear_req = 1'b0;
        repeat (8) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("t6_busy_after_rst", clear_busy, 0);
        chk("t6_front_after_rst", front_sel, 0);
        do_swap();
        for (int a = 0; a < P; a++) begin
            rd_addr = AW'(a);
            step();
            #1 chk("t6_rd_partial", rd_data, (a < 8) ? 4'h3 : 4'h5);
        end

        repeat (3000) begin
            reset       = ($urandom_range(0, 299) == 0);
            clear_req   = ($urandom_range(0, 39) == 0);
            swap_req    = ($urandom_range(0, 19) == 0);
            frame_start = ($urandom_range(0, 9) == 0);
            wr_valid    = 1'($urandom_range(0, 1));
            wr_addr     = AW'($urandom_range(0, 17));
            wr_data     = DW'($urandom);
            clear_color = DW'($urandom);
            rd_addr     = AW'($urandom_range(0, 20));
            step();
        end
        reset = 1'b0;
        idle_in();
        step();
        step();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/framebuffer_ctrl.md
Name: framebuffer_ctrl

Overview:
Double-buffered 4-bit-per-pixel framebuffer controller that sits directly upstream of screen_driver.
- Owns the frame BRAM (2 × PIXELS entries).
- Serves 1-cycle-latency pixel reads from the front buffer to the display side.
- Accepts renderer writes into the back buffer through a valid/ready port.
- Provides a hardware back-buffer clear engine.
- Swaps front/back only on a frame-start pulse, so the display never tears.

Parameters:
PIXELS, 192000, pixels per buffer; memory depth is 2*PIXELS
ADDR_W, 18, width of pixel address ports; must satisfy 2**ADDR_W >= PIXELS
DATA_W, 4, bits per pixel (palette index)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
rd_addr  in  ADDR_W  front-buffer pixel address from screen_driver
rd_data  out  DATA_W  pixel at rd_addr, registered, 1-cycle latency
frame_start  in  1  1-cycle pulse from screen_driver at start of vertical blank
wr_valid  in  1  renderer write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  ADDR_W  back-buffer pixel address
wr_data  in  DATA_W  pixel value
clear_req  in  1  request fill of back buffer with clear_color
clear_color  in  DATA_W  fill value, sampled with clear_req
clear_busy  out  1  high while clear engine runs
swap_req  in  1  request buffer swap at next frame_start
swap_pending  out  1  high while waiting for frame_start
swap_done  out  1  1-cycle pulse on the cycle after front_sel toggles
front_sel  out  1  buffer index being displayed (0 or 1)

Behaviour:
- Storage is simple dual-port RAM: one read port (display), one write port (write/clear). Physical address = buf*PIXELS + addr. The back buffer is !front_sel.
- Memory contents are not reset. Initial contents are don't-care.
- Reset values: state IDLE, front_sel 0, rd_data 0, clear_busy 0, swap_pending 0, swap_done 0.
- Read path:
  - rd_data(t+1) = front[rd_addr(t)] every cycle in every state.
  - rd_addr >= PIXELS returns 0.
  - A swap takes effect for reads issued on the cycle after the toggle.
- FSM has three states: IDLE, CLEAR, SWAP_WAIT.
- Priority in IDLE, same cycle: clear_req > swap_req > write.
- wr_ready = (state==IDLE) && !clear_req && !swap_req. This is combinational from the requests.
- IDLE transitions:
  - If clear_req: latch clear_color, set counter=0, go to CLEAR.
  - Else if swap_req: go to SWAP_WAIT.
  - Else if wr_valid: write wr_data to back[wr_addr]. wr_addr >= PIXELS is accepted but discarded (no write, no wrap).
- CLEAR:
  - Writes the latched color to back[counter] once per cycle, counter 0..PIXELS-1. This takes exactly PIXELS cycles.
  - Returns to IDLE after the write of PIXELS-1. clear_busy falls the same cycle the state becomes IDLE.
  - clear_req, swap_req and wr_valid are ignored, not queued.
  - frame_start is ignored.
- SWAP_WAIT:
  - On frame_start: toggle front_sel and go to IDLE. swap_done pulses high for the following cycle.
  - swap_pending = (state==SWAP_WAIT).
  - clear_req, swap_req and wr_valid are ignored.
- frame_start in IDLE or CLEAR has no effect.
- A swap_req and frame_start in the same IDLE cycle do not swap that cycle; the swap waits for the next frame_start.
- Reset mid-CLEAR aborts immediately; the partially cleared buffer stays. Reset in SWAP_WAIT cancels the swap and front_sel returns to 0.
- Counter width is ADDR_W. Terminal compare is against PIXELS-1, never a power of two.

Test Plan:
1. After reset with PIXELS=16: front_sel=0, wr_ready=1, clear_busy=0, swap_done=0. Read rd_addr=3 → rd_data=0 next cycle after a prior clear to 0.
2. Write wr_addr=5, wr_data=0xA (1 cycle). Then swap_req, then frame_start 4 cycles later → swap_pending high exactly those cycles, swap_done pulses once, front_sel=1. Read rd_addr=5 one cycle after → 0xA.
3. With PIXELS=16, clear_req with clear_color=0x7 → clear_busy high exactly 16 cycles, wr_ready=0 throughout. After a swap, reads of addresses 0..15 all return 0x7.
4. Simultaneous clear_req, swap_req and wr_valid in IDLE → clear runs, no swap pending afterwards, the write is not performed (wr_ready=0 that cycle).
5. frame_start while IDLE, and during CLEAR → front_sel unchanged, no swap_done. wr_addr=16 (out of range, PIXELS=16) → accepted, memory unchanged. rd_addr=20 → 0.
6. Reset asserted at clear cycle 8 → state IDLE next cycle. Entries 0..7 hold the clear color, entries 8..15 keep their old values. front_sel=0.
